eth_phy_10g_bert_ctrl: RTL and testbench
========================================

Name: eth_phy_10g_bert_ctrl

Overview:
- Bit-error-rate test sequencer for the 10G PHY.
- On `start` it resets the PHY, waits for RX block lock, and enables PRBS31 on TX and RX.
- It then ignores a settle interval, accumulates `rx_error_count` over a programmed window, and reports pass/fail against a limit.
- Sits beside the PHY instance in the RX clock domain; drives the PHY's reset and `cfg_*_prbs31_enable` inputs.

Parameters:
- RST_CYCLES, 16, PHY reset pulse length in cycles (>=1)
- LOCK_TIMEOUT, 4096, max cycles in WAIT_LOCK before timeout (>=2)
- SETTLE_CYCLES, 64, cycles after PRBS enable with errors ignored (>=1)
- WIN_W, 32, width of the measurement window counter
- ERR_W, 32, width of the error accumulator and limit

Ports:
- rx_clk  in  1  sole clock
- rx_rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begin test
- abort  in  1  single-cycle pulse; cancel test
- cfg_window  in  WIN_W  measurement cycles; sampled on accepted start
- cfg_err_limit  in  ERR_W  max allowed errors for pass; sampled on accepted start
- rx_block_lock  in  1  from PHY
- rx_high_ber  in  1  from PHY
- rx_error_count  in  7  per-cycle bit errors from PHY, 0..64
- phy_rst  out  1  active-high reset to PHY tx_rst/rx_rst
- cfg_tx_prbs31_enable  out  1  to PHY
- cfg_rx_prbs31_enable  out  1  to PHY
- busy  out  1  state not IDLE/DONE
- done  out  1  result valid
- pass  out  1  result: test passed
- timeout  out  1  result: lock never acquired
- lock_lost  out  1  result: lock dropped during MEASURE
- err_total  out  ERR_W  accumulated errors, saturating
- state  out  3  current state encoding

Behaviour:
- All outputs are registered. Reset value of every output is 0; state resets to IDLE.
- State encoding:
  - IDLE = 0
  - PHY_RST = 1
  - WAIT_LOCK = 2
  - SETTLE = 3
  - MEASURE = 4
  - DONE = 5
  - Codes 6 and 7 are illegal and go to IDLE next cycle.
- Start acceptance:
  - `start` is accepted only in IDLE or DONE.
  - On acceptance: clear done, pass, timeout, lock_lost and err_total; latch cfg_window (0 is treated as 1) and cfg_err_limit; go to PHY_RST.
  - `start` in any other state is ignored.
- Abort:
  - `abort` in any state goes to IDLE next cycle.
  - phy_rst and both enables drop to 0; result flags are cleared; err_total holds its value.
  - If start and abort are asserted together, abort wins.
- PHY_RST:
  - phy_rst = 1 for exactly RST_CYCLES cycles, starting the cycle after start.
  - Then go to WAIT_LOCK.
- WAIT_LOCK:
  - Counter starts at 0.
  - If rx_block_lock=1 and rx_high_ber=0 in the same cycle, go to SETTLE.
  - Otherwise, after LOCK_TIMEOUT cycles, go to DONE with timeout=1 and pass=0.
  - If lock qualifies on the final cycle, lock wins over timeout.
- SETTLE:
  - Both enables = 1 from the first SETTLE cycle.
  - rx_error_count is ignored.
  - After SETTLE_CYCLES cycles, go to MEASURE.
- MEASURE:
  - Enables stay 1.
  - Every cycle: err_total <= err_total + rx_error_count, saturating at 2^ERR_W-1 with no wrap.
  - Runs exactly the latched window of cycles; the last cycle's count is included.
  - rx_block_lock=0 in any MEASURE cycle: go to DONE with lock_lost=1 and pass=0; that cycle's count is still accumulated.
  - Normal end: pass = (final err_total <= latched limit).
- DONE:
  - Enables = 0, done = 1.
  - Results are held until the next accepted start or an abort.
- Latency: start in cycle 0 gives phy_rst in cycles 1..RST_CYCLES and state=WAIT_LOCK in cycle RST_CYCLES+1.
- Async reset mid-test: everything returns to reset values immediately.

Optional Feature:
- Macro: ETH_PHY_10G_BERT_RELOCK_EN.
- Defined:
  - Lock loss in MEASURE returns to WAIT_LOCK, with enables held at 1; err_total and the window counter are kept.
  - Up to 3 relocks per test; a 4th loss ends in DONE with lock_lost=1.
  - A relock timeout ends in DONE with timeout=1.
  - After relock the FSM passes through SETTLE again, and settle cycles do not count toward the window.
- Undefined: behaviour exactly as above; the relock counter is not present.

Decomposition:
- Package eth_phy_10g_bert_pkg holds:
  - the state localparams (IDLE..DONE)
  - the 3-bit state width
  - the rx_error_count width of 7
  - the relock limit of 3
- One natural sub-module, eth_bert_sat_acc: a parameterised saturating accumulator with clear, enable, and ERR_W-bit add of a 7-bit operand.

Test Plan:
- Bench parameters: RST_CYCLES=4, SETTLE_CYCLES=8, LOCK_TIMEOUT=32.
- Scenarios:
  - Lock high from PHY_RST exit, rx_error_count=0, cfg_window=100, limit=0, start -> phy_rst high 4 cycles; SETTLE 8 cycles; MEASURE 100 cycles; done=1, pass=1, err_total=0.
  - Same setup, rx_error_count=3 every MEASURE cycle and 50 every SETTLE cycle, limit=299 -> err_total=300, pass=0; limit=300 -> pass=1.
  - Lock never asserted -> done=1, timeout=1, pass=0 after 32 WAIT_LOCK cycles; enables never 1.
  - Lock dropped at MEASURE cycle 10 with count 1 per cycle -> done=1, lock_lost=1, err_total=11 (macro undefined).
  - ERR_W=8, rx_error_count=64 for 10 cycles -> err_total=255, no wrap, pass=0 with limit=200.
  - Abort and start in the same cycle during MEASURE -> IDLE next cycle, enables=0, done=0; a start two cycles later is accepted and clears err_total.

Source files
------------

// File: rtl/eth_phy_10g_bert_pkg.sv
// eth_phy_10g_bert_pkg: shared state encoding and widths for the 10G PHY BERT sequencer
package eth_phy_10g_bert_pkg;
  localparam int ST_W = 3;
  localparam int CNT_W = 7;
  localparam int RELOCK_MAX = 3;
  typedef enum logic [ST_W-1:0] {
    IDLE      = 3'd0,
    PHY_RST   = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    MEASURE   = 3'd4,
    DONE      = 3'd5
  } state_e;
endpackage

// File: rtl/eth_bert_sat_acc.sv
// eth_bert_sat_acc: ERR_W-bit accumulator of a small per-cycle operand that sticks at all-ones
module eth_bert_sat_acc
  import eth_phy_10g_bert_pkg::*;
#(
  parameter int ERR_W = 32,
  parameter int IN_W  = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [IN_W-1:0]  add,
  output logic [ERR_W-1:0] sum,
  output logic [ERR_W-1:0] nxt
);
  logic [ERR_W:0]   ext;
  logic [ERR_W-1:0] sum_q;
  always_comb begin
    ext = {1'b0, sum_q} + (ERR_W+1)'(add);
    nxt = clr ? '0 : en ? (ext[ERR_W] ? '1 : ext[ERR_W-1:0]) : sum_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else sum_q <= nxt;
  end
  assign sum = sum_q;
endmodule

// File: rtl/eth_phy_10g_bert_ctrl.sv
// eth_phy_10g_bert_ctrl: PRBS31 bit-error-rate test sequencer for the 10G PHY.
// Define ETH_PHY_10G_BERT_RELOCK_EN to let MEASURE survive up to RELOCK_MAX lock losses.
module eth_phy_10g_bert_ctrl
  import eth_phy_10g_bert_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int SETTLE_CYCLES = 64,
  parameter int WIN_W         = 32,
  parameter int ERR_W         = 32
) (
  input  logic             rx_clk,
  input  logic             rx_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic [ERR_W-1:0] cfg_err_limit,
  input  logic             rx_block_lock,
  input  logic             rx_high_ber,
  input  logic [CNT_W-1:0] rx_error_count,
  output logic             phy_rst,
  output logic             cfg_tx_prbs31_enable,
  output logic             cfg_rx_prbs31_enable,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             lock_lost,
  output logic [ERR_W-1:0] err_total,
  output logic [ST_W-1:0]  state
);
  state_e           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [WIN_W-1:0] win_q, win_d, win_len_q, win_len_d;
  logic [ERR_W-1:0] limit_q, limit_d, acc_nxt;
  logic             phy_rst_q, phy_rst_d, en_q, en_d, busy_q, busy_d;
  logic             done_q, done_d, pass_q, pass_d, timeout_q, timeout_d, lost_q, lost_d;
  logic             acc_clr, acc_en;
`ifdef ETH_PHY_10G_BERT_RELOCK_EN
  logic [1:0]       relock_q, relock_d;
`endif

  eth_bert_sat_acc #(.ERR_W(ERR_W), .IN_W(CNT_W)) u_acc (
    .clk(rx_clk), .rst_n(rx_rst_n), .clr(acc_clr), .en(acc_en),
    .add(rx_error_count), .sum(err_total), .nxt(acc_nxt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    win_len_d = win_len_q;
    limit_d   = limit_q;
    phy_rst_d = phy_rst_q;
    en_d      = en_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    lost_d    = lost_q;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
`ifdef ETH_PHY_10G_BERT_RELOCK_EN
    relock_d  = relock_q;
`endif
    if (abort) begin
      state_d   = IDLE;
      phy_rst_d = 1'b0;
      en_d      = 1'b0;
      {done_d, pass_d, timeout_d, lost_d} = '0;
    end else if (start && (state_q == IDLE || state_q == DONE)) begin
      state_d   = PHY_RST;
      cnt_d     = '0;
      win_d     = '0;
      win_len_d = (cfg_window == '0) ? WIN_W'(1) : cfg_window;
      limit_d   = cfg_err_limit;
      phy_rst_d = 1'b1;
      en_d      = 1'b0;
      {done_d, pass_d, timeout_d, lost_d} = '0;
      acc_clr   = 1'b1;
`ifdef ETH_PHY_10G_BERT_RELOCK_EN
      relock_d  = '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: ;
        PHY_RST: begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == 32'(RST_CYCLES - 1)) begin
            state_d   = WAIT_LOCK;
            cnt_d     = '0;
            phy_rst_d = 1'b0;
          end
        end
        WAIT_LOCK: begin
          cnt_d = cnt_q + 32'd1;
          if (rx_block_lock && !rx_high_ber) begin
            state_d = SETTLE;
            cnt_d   = '0;
            en_d    = 1'b1;
          end else if (cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
            state_d   = DONE;
            en_d      = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end
        SETTLE: begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
            state_d = MEASURE;
            cnt_d   = '0;
          end
        end
        MEASURE: begin
          acc_en = 1'b1;
          win_d  = win_q + 1'b1;
          if (!rx_block_lock) begin
`ifdef ETH_PHY_10G_BERT_RELOCK_EN
            if (relock_q < 2'(RELOCK_MAX)) begin
              state_d  = WAIT_LOCK;
              cnt_d    = '0;
              relock_d = relock_q + 2'd1;
            end else
`endif
            begin
              state_d = DONE;
              en_d    = 1'b0;
              done_d  = 1'b1;
              lost_d  = 1'b1;
            end
          end else if (win_q == win_len_q - 1'b1) begin
            state_d = DONE;
            en_d    = 1'b0;
            done_d  = 1'b1;
            pass_d  = acc_nxt <= limit_q;
          end
        end
        default: begin
          state_d   = IDLE;
          phy_rst_d = 1'b0;
          en_d      = 1'b0;
        end
      endcase
    end
    busy_d = state_d != IDLE && state_d != DONE;
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      win_q     <= '0;
      win_len_q <= '0;
      limit_q   <= '0;
      phy_rst_q <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      lost_q    <= 1'b0;
`ifdef ETH_PHY_10G_BERT_RELOCK_EN
      relock_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      win_len_q <= win_len_d;
      limit_q   <= limit_d;
      phy_rst_q <= phy_rst_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      lost_q    <= lost_d;
`ifdef ETH_PHY_10G_BERT_RELOCK_EN
      relock_q  <= relock_d;
`endif
    end
  end

  assign phy_rst              = phy_rst_q;
  assign cfg_tx_prbs31_enable = en_q;
  assign cfg_rx_prbs31_enable = en_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign pass                 = pass_q;
  assign timeout              = timeout_q;
  assign lock_lost            = lost_q;
  assign state                = state_q;
endmodule

// File: tb/tb_eth_phy_10g_bert_ctrl.sv
// tb_eth_phy_10g_bert_ctrl: scoreboard bench; a 32-bit and an 8-bit accumulator instance share stimulus
module tb_eth_phy_10g_bert_ctrl;
  localparam int RC = 4, LT = 32, SC = 8;
  logic        rx_clk = 0, rx_rst_n = 0, start = 0, abort = 0, lock = 0, hber = 0;
  logic [31:0] win = 0, lim = 0;
  logic [6:0]  errc = 0;
  logic        phy_rst, tx_en, rx_en, busy, done, pass, timeout, lock_lost;
  logic [31:0] err_total;
  logic [2:0]  state;
  logic        phy_rst_b, tx_b, rx_b, busy_b, done_b, pass_b, timeout_b, lost_b;
  logic [7:0]  err_b;
  logic [2:0]  state_b;
  int          total = 0, bad = 0;

  typedef struct packed {
    logic        pass, timeout, lost, pass8;
    logic [31:0] tot;
    logic [7:0]  tot8;
  } exp_t;
  exp_t sb[$];

  always #5 rx_clk = ~rx_clk;

  eth_phy_10g_bert_ctrl #(.RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SC), .WIN_W(32), .ERR_W(32)) dut (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .start(start), .abort(abort), .cfg_window(win),
    .cfg_err_limit(lim), .rx_block_lock(lock), .rx_high_ber(hber), .rx_error_count(errc),
    .phy_rst(phy_rst), .cfg_tx_prbs31_enable(tx_en), .cfg_rx_prbs31_enable(rx_en), .busy(busy),
    .done(done), .pass(pass), .timeout(timeout), .lock_lost(lock_lost), .err_total(err_total), .state(state)
  );

  eth_phy_10g_bert_ctrl #(.RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .SETTLE_CYCLES(SC), .WIN_W(32), .ERR_W(8)) dut_b (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .start(start), .abort(abort), .cfg_window(win),
    .cfg_err_limit(lim[7:0]), .rx_block_lock(lock), .rx_high_ber(hber), .rx_error_count(errc),
    .phy_rst(phy_rst_b), .cfg_tx_prbs31_enable(tx_b), .cfg_rx_prbs31_enable(rx_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .timeout(timeout_b), .lock_lost(lost_b), .err_total(err_b), .state(state_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // lock_at<0: lock never; drop_at: MEASURE cycle with lock low; abort_at: MEASURE cycle of abort+start
  task automatic run(input string tag, input int w, input int l, input int lock_at,
                     input int drop_at, input int abort_at, input int se, input int me);
    exp_t e, g;
    int ww, n, wl, mc, sc, pr, first_wl;
    bit en_seen, fin;
    longint t;
    ww = (w == 0) ? 1 : w;
    e = '0;
    if (abort_at >= 0) n = abort_at;
    else if (lock_at < 0 || lock_at >= LT) begin n = 0; e.timeout = 1; end
    else if (drop_at >= 0 && drop_at < ww) begin n = drop_at + 1; e.lost = 1; end
    else n = ww;
    t = longint'(me) * n;
    e.tot  = t[31:0];
    e.tot8 = (t > 255) ? 8'hff : t[7:0];
    if (abort_at < 0 && !e.timeout && !e.lost) begin
      e.pass  = t <= l;
      e.pass8 = e.tot8 <= 8'(l % 256);
    end
    sb.push_back(e);
    {wl, mc, sc, pr, first_wl, en_seen, fin} = '0;
    @(negedge rx_clk);
    start = 1; win = w; lim = l;
    for (int i = 1; i <= 1000 && !fin; i++) begin
      @(negedge rx_clk);
      start = 0;
      if (i == 1) begin
        check({tag, ".clr"}, err_total, 0);
        check({tag, ".busy"}, busy, 1);
      end
      if (state == 3'd2 && first_wl == 0) first_wl = i;
      pr += int'(phy_rst);
      en_seen |= tx_en | rx_en;
      if (state == 3'd3) sc++;
      if (abort_at >= 0 && state == 3'd4 && mc == abort_at) begin
        abort = 1; start = 1;
        @(negedge rx_clk);
        abort = 0; start = 0;
        check({tag, ".ab_state"}, state, 0);
        check({tag, ".ab_en"}, {tx_en, rx_en}, 0);
        check({tag, ".ab_done"}, done, 0);
        fin = 1;
      end else if (done) begin
        check({tag, ".state"}, state, 5);
        check({tag, ".en_off"}, {tx_en, rx_en}, 0);
        fin = 1;
      end else begin
        lock = lock_at >= 0 && (state != 3'd2 || wl >= lock_at) && !(state == 3'd4 && mc == drop_at);
        errc = (state == 3'd3) ? 7'(se) : (state == 3'd4) ? 7'(me) : 7'd0;
        if (state == 3'd2) wl++;
        if (state == 3'd4) mc++;
      end
    end
    g = sb.pop_front();
    if (!fin) check({tag, ".hang"}, 0, 1);
    check({tag, ".pass"}, pass, g.pass);
    check({tag, ".timeout"}, timeout, g.timeout);
    check({tag, ".lost"}, lock_lost, g.lost);
    check({tag, ".err"}, err_total, g.tot);
    check({tag, ".err8"}, err_b, g.tot8);
    check({tag, ".pass8"}, pass_b, g.pass8);
    check({tag, ".rst_len"}, pr, RC);
    check({tag, ".wl_lat"}, first_wl, RC + 1);
    check({tag, ".meas_n"}, mc, n);
    if (g.timeout) begin
      check({tag, ".wl_n"}, wl, LT);
      check({tag, ".en_never"}, en_seen, 0);
    end else check({tag, ".settle_n"}, sc, SC);
    lock = 0; errc = 0;
  endtask

  initial begin
    repeat (2) @(negedge rx_clk);
    check("rst.state", state, 0);
    check("rst.outs", {phy_rst, tx_en, rx_en, busy, done, pass, timeout, lock_lost}, 0);
    check("rst.err", err_total, 0);
    rx_rst_n = 1;
    @(negedge rx_clk);
    run("clean",   100,   0,  0, -1, -1,  0,  0);
    run("lim299",  100, 299,  0, -1, -1, 50,  3);
    run("lim300",  100, 300,  0, -1, -1, 50,  3);
    run("tmo",     100,   0, -1, -1, -1,  0,  0);
    run("drop",    100, 500,  0, 10, -1,  0,  1);
    run("sat",      10, 200,  0, -1, -1,  0, 64);
    run("lastlk",    0,   1, 31, -1, -1,  0,  2);
    run("abort",   100,   0,  0, -1,  5,  0,  3);
    run("restart",  20,   5,  0, -1, -1,  9,  0);
    @(negedge rx_clk);
    start = 1; win = 50; lim = 0;
    @(negedge rx_clk);
    start = 0;
    repeat (3) @(negedge rx_clk);
    #2 rx_rst_n = 0;
    #1 check("arst.state", state, 0);
    check("arst.phy_rst", phy_rst, 0);
    check("arst.busy", busy, 0);
    @(negedge rx_clk);
    rx_rst_n = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
